// File: rtl/gbtx_frame_tx_if.sv
// gbtx_frame_tx_if: DAQ word handshake between a producer and the GBTx frame transmitter.
//   in_word  : DAQ word (DW bits), driven by master
//   in_valid : word offered, driven by master
//   in_ready : word can be taken, driven by slave
interface gbtx_frame_tx_if #(parameter int DW = 19);
  logic [DW-1:0] in_word;
  logic          in_valid;
  logic          in_ready;
  modport master (output in_word, in_valid, input in_ready);
  modport slave  (input in_word, in_valid, output in_ready);
endinterface

// File: rtl/gbtx_frame_tx.sv
// gbtx_frame_tx: buffers DAQ words in a FIFO and emits GBTx e-link DDR half-frames.
//   clk, rst_n   : 160 MHz e-link clock, asynchronous active-low reset
//   daq          : DAQ word handshake (gbtx_frame_tx_if.slave)
//   gbt_txrdy    : GBTx transmitter ready (already synchronised)
//   el0, el1     : registered first/second half-frame lane data
//   dv           : registered data-valid, aligned with el0/el1
//   ovf_cnt      : dropped-word count (saturating), frame_cnt: data frames sent
//   state        : 0 WAIT, 1 ALIGN, 2 RUN
//   Macro GBTX_FRAME_TX_STATS_EN builds ovf_cnt/frame_cnt; otherwise both read 0.
module gbtx_frame_tx #(
  parameter int DW           = 19,
  parameter int LANES        = 14,
  parameter int DEPTH        = 16,
  parameter int IDLE_W       = 3,
  parameter int ALIGN_FRAMES = 8,
  parameter int DROP_ON_FULL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  gbtx_frame_tx_if.slave    daq,
  input  logic              gbt_txrdy,
  output logic [LANES-1:0]  el0,
  output logic [LANES-1:0]  el1,
  output logic              dv,
  output logic [15:0]       ovf_cnt,
  output logic [31:0]       frame_cnt,
  output logic [1:0]        state
);
  localparam int H  = (DW + 1) / 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ALIGN_FRAMES + 1);
  localparam logic [1:0] S_WAIT = 2'd0, S_ALIGN = 2'd1, S_RUN = 2'd2;
  if (H + IDLE_W > LANES - 1) begin : g_bad_lanes
    $error("gbtx_frame_tx: H + IDLE_W must not exceed LANES-1");
  end
  if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("gbtx_frame_tx: DEPTH must be a power of 2 and at least 4");
  end
  logic [DW-1:0]    mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    acnt_q, acnt_d;
  logic [IDLE_W-1:0] idle_q;
  logic [LANES-1:0] el0_q, el1_q, el0_d, el1_d;
  logic             dv_q, empty, full, rd, wr;
  logic [DW-1:0]    rword;
  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign daq.in_ready = rst_n && (DROP_ON_FULL != 0 || !full);
  assign rd    = state_q == S_RUN && !empty;
  // A read in the same cycle frees the slot, so a write while full is still taken
  assign wr    = daq.in_valid && daq.in_ready && (!full || rd);
  assign rword = mem_q[rptr_q[AW-1:0]];
  always_comb begin
    acnt_d  = !gbt_txrdy ? '0 : state_q == S_RUN ? acnt_q : acnt_q + 1'b1;
    // acnt_q counts ready cycles already seen; this cycle completes the run of ALIGN_FRAMES
    state_d = !gbt_txrdy ? S_WAIT :
              (state_q == S_RUN || acnt_q == CW'(ALIGN_FRAMES - 1)) ? S_RUN : S_ALIGN;
    el0_d = '0;
    el1_d = '0;
    el0_d[LANES-1]     = 1'b1;
    el0_d[H +: IDLE_W] = idle_q;
    el1_d[H +: IDLE_W] = idle_q;
    el0_d[H-1:0]       = rd ? rword[H-1:0] : '0;
    el1_d[DW-H-1:0]    = rd ? rword[DW-1:H] : '0;
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= daq.in_word;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= S_WAIT;
      acnt_q  <= '0;
      idle_q  <= '0;
      el0_q   <= '0;
      el1_q   <= '0;
      dv_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_q + (AW+1)'(wr);
      rptr_q  <= rptr_q + (AW+1)'(rd);
      state_q <= state_d;
      acnt_q  <= acnt_d;
      idle_q  <= idle_q + 1'b1;
      el0_q   <= el0_d;
      el1_q   <= el1_d;
      dv_q    <= rd;
    end
  end
`ifdef GBTX_FRAME_TX_STATS_EN
  logic        drop;
  logic [15:0] ovf_q;
  logic [31:0] frame_q;
  assign drop = daq.in_valid && daq.in_ready && full && !rd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q   <= '0;
      frame_q <= '0;
    end else begin
      if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 1'b1;
      frame_q <= frame_q + 32'(rd);
    end
  end
  assign ovf_cnt   = ovf_q;
  assign frame_cnt = frame_q;
`else
  assign ovf_cnt   = '0;
  assign frame_cnt = '0;
`endif
  assign el0   = el0_q;
  assign el1   = el1_q;
  assign dv    = dv_q;
  assign state = state_q;
endmodule
